lcd_frame_reader: RTL and testbench
===================================

// Module: lcd_frame_reader
// PURPOSE
//  Read side of the camera frame path. Generates 800x480 LCD raster timing, pulls packed pixels from the
//  SDRAM read FIFO and unpacks them to 8-bit RGB for the LCD.
//  Unpacking is the exact inverse of the SDRAM write packing: R=rd1[9:2], G={rd1[14:10],rd2[14:12]}, B=rd2[9:2].
// PARAMETERS
//  H_ACTIVE  800  visible pixels per line
//  H_FP      40   horizontal front porch, clocks
//  H_SYNC    48   HSYNC pulse width, clocks
//  H_BP      40   horizontal back porch, clocks (line total = 928)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      13   vertical front porch, lines
//  V_SYNC    3    VSYNC pulse width, lines
//  V_BP      29   vertical back porch, lines (frame total = 525)
// PORTS
//  iClk         in   1   pixel clock; all logic on rising edge
//  iRst         in   1   synchronous, active-high reset
//  iEnable      in   1   display enable; sampled only at frame boundary
//  iFifo_empty  in   1   SDRAM read FIFO empty
//  iRd1_data    in   16  FIFO port 1 word; valid the cycle after oRead
//  iRd2_data    in   16  FIFO port 2 word; valid the cycle after oRead
//  oRead        out  1   FIFO read request, one word per port per pulse
//  oLCD_R       out  8   red, registered
//  oLCD_G       out  8   green, registered
//  oLCD_B       out  8   blue, registered
//  oDE          out  1   data enable, aligned with RGB
//  oHSync_n     out  1   active-low HSYNC, aligned with oDE
//  oVSync_n     out  1   active-low VSYNC, aligned with oDE
//  oX_Cont      out  16  column of the pixel on oLCD_*, 0..799
//  oY_Cont      out  16  row of the pixel on oLCD_*, 0..479
//  oFrameStart  out  1   1-cycle pulse with pixel (0,0) on oDE
//  oUnderflow   out  1   sticky: a read was issued while the FIFO was empty
// BEHAVIOUR
//  Reset: outputs 0 except oHSync_n=1 and oVSync_n=1; hcnt=vcnt=0; state=IDLE; oUnderflow cleared.
//  Counters
//   - hcnt runs 0..927 and wraps to 0; vcnt increments on each hcnt wrap and runs 0..524, wrapping to 0.
//   - Active window: hcnt<800 and vcnt<480. Sync: hcnt in [840,888); vcnt in [493,496).
//   - Counters run in every state, so sync timing is always present.
//  FSM
//   - IDLE: oRead=0 and oDE=0. Goes to RUN at hcnt=0,vcnt=0 when iEnable=1.
//   - RUN: oRead=1 in every active-window cycle.
//     At the frame end (hcnt=927,vcnt=524): goes to IDLE if iEnable=0, otherwise stays in RUN.
//   - Deasserting iEnable mid-frame never truncates the frame. Asserting it mid-frame waits for the next (0,0).
//  Pipeline, latency 2 clocks from counter to output
//   - Cycle N: oRead and window decode.
//   - Cycle N+1: iRd1_data/iRd2_data valid; the 1-cycle-delayed read flag marks capture.
//   - Cycle N+2: oLCD_*, oDE, oX_Cont/oY_Cont registered.
//   - oHSync_n/oVSync_n are delayed 2 clocks so they stay aligned with oDE.
//  Unpacking: R=rd1[9:2]; G={rd1[14:10],rd2[14:12]}; B=rd2[9:2].
//  Blanking: when oDE=0, RGB is forced to 0.
//  Underflow
//   - oRead while iFifo_empty=1: that pixel outputs RGB=0 with oDE still 1, and oUnderflow sets.
//   - The read is still issued; the FIFO ignores reads while empty. Pixel count and timing are unaffected.
//   - oUnderflow clears only on iRst.
//  Reset mid-frame: pipeline flushed, the next cycle shows the reset values, and the raster restarts at (0,0).
// TESTING
//  1. Reset: iRst=1 for 4 clocks -> all outputs at reset values. Release with iEnable=0 -> oDE=0 always.
//     oHSync_n low for exactly 48 clocks every 928.
//  2. Enable and latency: iEnable=1 at reset release, FIFO non-empty.
//     First oRead at clock 0 -> oDE=1 with oFrameStart=1 and oX_Cont=0/oY_Cont=0 at clock 2.
//     oRead count per frame is exactly 384000.
//  3. Packing: rd1=16'h56CC, rd2=16'h3004 -> oLCD_R=8'hB3, oLCD_G=8'hAB, oLCD_B=8'h01.
//  4. Wrap: oX_Cont runs 799 then 0 on the next active line. The last pixel is (799,479).
//     oVSync_n is low for 3*928 clocks per 525-line frame.
//  5. Underflow: iFifo_empty=1 for pixels 100..102 of line 5 -> those pixels RGB=0 with oDE=1; oUnderflow=1 to end.
//  6. Enable edges: iEnable=0 at line 200 -> the frame completes, then oDE=0 and oRead=0.
//     Also iRst at line 300 -> restart at (0,0).

Source files
------------

// File: rtl/lcd_frame_reader_if.sv
// Pixel-path bundle between the SDRAM read FIFO, the frame reader and the LCD.
// master = frame reader side, slave = FIFO/LCD/environment side.
interface lcd_frame_reader_if;
    logic        iEnable;
    logic        iFifo_empty;
    logic [15:0] iRd1_data;
    logic [15:0] iRd2_data;
    logic        oRead;
    logic [7:0]  oLCD_R;
    logic [7:0]  oLCD_G;
    logic [7:0]  oLCD_B;
    logic        oDE;
    logic        oHSync_n;
    logic        oVSync_n;
    logic [15:0] oX_Cont;
    logic [15:0] oY_Cont;
    logic        oFrameStart;
    logic        oUnderflow;

    modport master (
        input  iEnable, iFifo_empty, iRd1_data, iRd2_data,
        output oRead, oLCD_R, oLCD_G, oLCD_B, oDE, oHSync_n, oVSync_n,
               oX_Cont, oY_Cont, oFrameStart, oUnderflow
    );

    modport slave (
        output iEnable, iFifo_empty, iRd1_data, iRd2_data,
        input  oRead, oLCD_R, oLCD_G, oLCD_B, oDE, oHSync_n, oVSync_n,
               oX_Cont, oY_Cont, oFrameStart, oUnderflow
    );
endinterface

// File: rtl/lcd_frame_reader.sv
// LCD raster generator and read-FIFO unpacker: free-running h/v counters, frame-granular
// enable FSM, and a 2-stage pipeline from counter decode to registered RGB/sync outputs.
module lcd_frame_reader #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 48,
    parameter int unsigned H_BP     = 40,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 13,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BP     = 29
) (
    input  logic               iClk,
    input  logic               iRst,
    lcd_frame_reader_if.master lcd
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
    localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [15:0] hcnt;
    logic [15:0] vcnt;
    logic [0:0]  state;
    logic [0:0]  state_nxt;

    logic h_wrap;
    logic frame_first;
    logic frame_last;
    logic active;
    logic hs_win;
    logic vs_win;
    logic run_now;
    logic rd_req;

    // Stage 1: read issued last cycle, FIFO data valid now
    logic        rd_d1;
    logic        und_d1;
    logic        fs_d1;
    logic        hs_n_d1;
    logic        vs_n_d1;
    logic [15:0] x_d1;
    logic [15:0] y_d1;
    logic        pix_ok;

    logic unused_bits;
    assign unused_bits = ^{lcd.iRd1_data[15], lcd.iRd1_data[1:0],
                           lcd.iRd2_data[15], lcd.iRd2_data[11:10], lcd.iRd2_data[1:0]};

    always_comb begin
        h_wrap      = (hcnt == H_LAST);
        frame_first = (hcnt == '0) && (vcnt == '0);
        frame_last  = h_wrap && (vcnt == V_LAST);
        active      = (hcnt < H_ACT) && (vcnt < V_ACT);
        hs_win      = (hcnt >= HS_BEG) && (hcnt < HS_END);
        vs_win      = (vcnt >= VS_BEG) && (vcnt < VS_END);
        // The frame that starts while enabled is already read in its (0,0) cycle
        run_now     = (state == ST_RUN) || (frame_first && lcd.iEnable);
        rd_req      = !iRst && run_now && active;
    end

    assign lcd.oRead = rd_req;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_wrap) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 16'd1;
        end else begin
            hcnt <= hcnt + 16'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (frame_first && lcd.iEnable) state_nxt = ST_RUN;
            ST_RUN:  if (frame_last && !lcd.iEnable) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            rd_d1   <= 1'b0;
            und_d1  <= 1'b0;
            fs_d1   <= 1'b0;
            hs_n_d1 <= 1'b1;
            vs_n_d1 <= 1'b1;
            x_d1    <= '0;
            y_d1    <= '0;
        end else begin
            rd_d1   <= rd_req;
            und_d1  <= rd_req && lcd.iFifo_empty;
            fs_d1   <= rd_req && frame_first;
            hs_n_d1 <= !hs_win;
            vs_n_d1 <= !vs_win;
            x_d1    <= hcnt;
            y_d1    <= vcnt;
        end
    end

    // A read against an empty FIFO still occupies its pixel slot, shown black
    assign pix_ok = rd_d1 && !und_d1;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            lcd.oLCD_R      <= '0;
            lcd.oLCD_G      <= '0;
            lcd.oLCD_B      <= '0;
            lcd.oDE         <= 1'b0;
            lcd.oHSync_n    <= 1'b1;
            lcd.oVSync_n    <= 1'b1;
            lcd.oX_Cont     <= '0;
            lcd.oY_Cont     <= '0;
            lcd.oFrameStart <= 1'b0;
            lcd.oUnderflow  <= 1'b0;
        end else begin
            lcd.oDE         <= rd_d1;
            lcd.oLCD_R      <= pix_ok ? lcd.iRd1_data[9:2] : '0;
            lcd.oLCD_G      <= pix_ok ? {lcd.iRd1_data[14:10], lcd.iRd2_data[14:12]} : '0;
            lcd.oLCD_B      <= pix_ok ? lcd.iRd2_data[9:2] : '0;
            lcd.oHSync_n    <= hs_n_d1;
            lcd.oVSync_n    <= vs_n_d1;
            lcd.oFrameStart <= fs_d1;
            lcd.oUnderflow  <= lcd.oUnderflow | und_d1;
            if (rd_d1) begin
                lcd.oX_Cont <= x_d1;
                lcd.oY_Cont <= y_d1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_frame_reader.sv
// Bench for lcd_frame_reader on a shrunken raster: packing vectors, directed enable/reset
// sequences, and random stimulus against a time-indexed raster model.
module tb_lcd_frame_reader;

    localparam int HA  = 16;
    localparam int HFP = 4;
    localparam int HS  = 5;
    localparam int HBP = 3;
    localparam int VA  = 10;
    localparam int VFP = 2;
    localparam int VS  = 3;
    localparam int VBP = 2;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FR  = HT * VT;
    localparam int HMAX = 4096;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   t     = 0;

    lcd_frame_reader_if bus();

    lcd_frame_reader #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .iClk(clk),
        .iRst(rst),
        .lcd (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } vec_t;

    vec_t vt[8];

    bit          en_h [HMAX];
    bit          em_h [HMAX];
    bit          rd_h [HMAX];
    logic [15:0] d1_h [HMAX];
    logic [15:0] d2_h [HMAX];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, t);
        end
    endtask

    function automatic logic [23:0] unpack(input logic [15:0] a, input logic [15:0] b);
        return {a[9:2], a[14:10], b[14:12], b[9:2]};
    endfunction

    task automatic chk_reset_vals();
        chk("rst_oRead", 32'(bus.oRead), 32'(0));
        chk("rst_oDE", 32'(bus.oDE), 32'(0));
        chk("rst_rgb", 32'({bus.oLCD_R, bus.oLCD_G, bus.oLCD_B}), 32'(0));
        chk("rst_hs", 32'(bus.oHSync_n), 32'(1));
        chk("rst_vs", 32'(bus.oVSync_n), 32'(1));
        chk("rst_xy", 32'({bus.oX_Cont, bus.oY_Cont}), 32'(0));
        chk("rst_fs", 32'(bus.oFrameStart), 32'(0));
        chk("rst_und", 32'(bus.oUnderflow), 32'(0));
    endtask

    // Entered and left at 1 time unit after a rising edge
    task automatic do_reset(input int n, input bit en);
        rst = 1'b1;
        bus.iEnable = en;
        bus.iFifo_empty = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_gate_oRead", 32'(bus.oRead), 32'(0));
            if (i > 0) chk_reset_vals();
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    // Model: cycle c after reset release sits at raster position c mod FR; a frame is read
    // iff enable is high at its first cycle, or the previous frame was read and enable was
    // high at its last cycle. Outputs show position c-2 with FIFO data driven at c-1.
    task automatic run(input int n, input int mode);
        int p, h, v, s, h2, v2, frd, fhs, fvs;
        bit en, em, en_r, fr_en, und_m, e_de, e_hs, e_vs, e_fs;
        logic [23:0] px;
        en_r = 1'b1; fr_en = 1'b0; und_m = 1'b0;
        frd = 0; fhs = 0; fvs = 0; h2 = 0; v2 = 0;
        for (int c = 0; c < n; c++) begin
            t = c;
            p = c % FR; h = p % HT; v = p / HT;
            case (mode)
                0: begin en = 1'b0; em = 1'b0; end
                1: begin en = 1'b1; em = 1'b0; end
                2: begin en = 1'b1; em = (v == 5 && h >= 10 && h <= 12); end
                3: begin en = (c < 6 * HT); em = 1'b0; end
                5: begin en = (c >= 3 * HT + 5); em = 1'b0; end
                default: begin
                    if ($urandom_range(0, 59) == 0) en_r = ~en_r;
                    en = en_r;
                    em = ($urandom_range(0, 31) == 0);
                end
            endcase
            bus.iEnable     = en;
            bus.iFifo_empty = em;
            bus.iRd1_data   = 16'($urandom);
            bus.iRd2_data   = 16'($urandom);
            en_h[c] = en; em_h[c] = em;
            d1_h[c] = bus.iRd1_data; d2_h[c] = bus.iRd2_data;
            if (p == 0) fr_en = (c == 0) ? en : ((fr_en && en_h[c-1]) || en);
            rd_h[c] = fr_en && h < HA && v < VA;

            @(negedge clk);
            chk("oRead", 32'(bus.oRead), 32'(rd_h[c]));
            if (c < 2) begin
                e_de = 1'b0; px = '0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
            end else begin
                s = c - 2; h2 = (s % FR) % HT; v2 = (s % FR) / HT;
                e_de = rd_h[s];
                if (rd_h[s] && em_h[s]) und_m = 1'b1;
                px   = (rd_h[s] && !em_h[s]) ? unpack(d1_h[c-1], d2_h[c-1]) : '0;
                e_hs = !(h2 >= HA + HFP && h2 < HA + HFP + HS);
                e_vs = !(v2 >= VA + VFP && v2 < VA + VFP + VS);
                e_fs = rd_h[s] && h2 == 0 && v2 == 0;
            end
            chk("oDE", 32'(bus.oDE), 32'(e_de));
            chk("rgb", 32'({bus.oLCD_R, bus.oLCD_G, bus.oLCD_B}), 32'(px));
            chk("oHSync_n", 32'(bus.oHSync_n), 32'(e_hs));
            chk("oVSync_n", 32'(bus.oVSync_n), 32'(e_vs));
            chk("oFrameStart", 32'(bus.oFrameStart), 32'(e_fs));
            chk("oUnderflow", 32'(bus.oUnderflow), 32'(und_m));
            if (e_de) begin
                chk("oX_Cont", 32'(bus.oX_Cont), 32'(h2));
                chk("oY_Cont", 32'(bus.oY_Cont), 32'(v2));
            end

            frd += int'(bus.oRead);
            fhs += int'(!bus.oHSync_n);
            fvs += int'(!bus.oVSync_n);
            if (p == FR - 1) begin
                chk("reads_per_frame", 32'(frd), 32'(fr_en ? HA * VA : 0));
                chk("hsync_low_per_frame", 32'(fhs), 32'(HS * VT));
                chk("vsync_low_per_frame", 32'(fvs), 32'(VS * HT));
                frd = 0; fhs = 0; fvs = 0;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vt[0] = '{16'h56CC, 16'h3004, 8'hB3, 8'hAB, 8'h01};
        vt[1] = '{16'hFFFF, 16'hFFFF, 8'hFF, 8'hFF, 8'hFF};
        vt[2] = '{16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00};
        vt[3] = '{16'h8003, 16'h8003, 8'h00, 8'h00, 8'h00};
        vt[4] = '{16'h7C00, 16'h0000, 8'h00, 8'hF8, 8'h00};
        vt[5] = '{16'h0000, 16'h7000, 8'h00, 8'h07, 8'h00};
        vt[6] = '{16'h03FC, 16'h03FC, 8'hFF, 8'h00, 8'hFF};
        vt[7] = '{16'h1234, 16'hABCD, 8'h8D, 8'h22, 8'hF3};

        rst = 1'b1;
        bus.iEnable = 1'b0; bus.iFifo_empty = 1'b0;
        bus.iRd1_data = '0; bus.iRd2_data = '0;
        @(posedge clk); #1;

        do_reset(4, 1'b0);
        run(2 * FR, 0);

        // Packing vectors on the first pixels of line 0
        do_reset(2, 1'b1);
        t = 0;
        @(negedge clk);
        chk("first_read", 32'(bus.oRead), 32'(1));
        @(posedge clk); #1;
        for (int c = 1; c <= 9; c++) begin
            t = c;
            if (c <= 8) begin
                bus.iRd1_data = vt[c-1].rd1;
                bus.iRd2_data = vt[c-1].rd2;
            end
            @(negedge clk);
            chk("latency_de", 32'(bus.oDE), 32'(c >= 2));
            if (c >= 2) begin
                chk("vec_R", 32'(bus.oLCD_R), 32'(vt[c-2].r));
                chk("vec_G", 32'(bus.oLCD_G), 32'(vt[c-2].g));
                chk("vec_B", 32'(bus.oLCD_B), 32'(vt[c-2].b));
                chk("vec_X", 32'(bus.oX_Cont), 32'(c - 2));
                chk("vec_Y", 32'(bus.oY_Cont), 32'(0));
                chk("vec_fs", 32'(bus.oFrameStart), 32'(c == 2));
            end
            @(posedge clk); #1;
        end

        do_reset(2, 1'b1);
        run(2 * FR + 10, 1);

        do_reset(2, 1'b1);
        run(FR, 2);
        @(negedge clk);
        chk("underflow_sticky", 32'(bus.oUnderflow), 32'(1));
        @(posedge clk); #1;

        do_reset(2, 1'b1);
        run(3 * FR, 3);

        do_reset(2, 1'b0);
        run(2 * FR, 5);

        do_reset(2, 1'b1);
        run(8 * HT + 7, 1);
        do_reset(2, 1'b1);
        run(FR + 5, 1);

        do_reset(2, 1'b1);
        run(4 * FR, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
